// File: rtl/sync_fifo_drain_if.sv
// sync_fifo_drain_if: bundles the FIFO read-side signals and the downstream
// valid/ready stream of the sync_fifo_drain controller.
// The master modport is the controller's view. The slave modport is the
// FIFO-plus-consumer side.
interface sync_fifo_drain_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  flush,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output flush,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sync_fifo_drain.sv
// sync_fifo_drain: read-side controller for a synchronous FIFO.
// It issues fifo_rd_en and captures the registered fifo_dout one cycle later
// into a 2-entry holding buffer. It then re-presents the words on a
// valid/ready stream at up to one beat per cycle.
// Optional macro DRAIN_STATS_EN adds the beat_cnt and drop_cnt statistics outputs.
module sync_fifo_drain #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  rst,
    sync_fifo_drain_if.master     bus
`ifdef DRAIN_STATS_EN
    ,
    output logic [31:0]           beat_cnt,
    output logic [31:0]           drop_cnt
`endif
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    logic       m_valid;
    logic       pop;
    logic       push;
    logic       rd_en;
    logic [2:0] level;

    // Handshake decode, read request and next-state for occupancy/indices/buffer
    always_comb begin
        level      = {1'b0, occ_q} + {2'd0, inflight_q};
        m_valid    = (occ_q != 2'd0) && !rst;
        pop        = m_valid && bus.m_ready;
        rd_en      = !rst && !bus.flush && !bus.fifo_empty
                     && (level < (3'd2 + {2'd0, pop}));
        push       = inflight_q && !bus.flush;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        head_d     = head_q;
        tail_d     = tail_q;
        for (int i = 0; i < 2; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (bus.flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
        end else begin
            if (push) begin
                buf_d[tail_q] = bus.fifo_dout;
                tail_d        = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
            inflight_d = rd_en;
        end
    end

    // Control state register; reset returns the controller to empty and idle
    always_ff @(posedge clock) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Holding buffer storage; contents only matter while counted in occ
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

    assign bus.m_valid    = m_valid;
    assign bus.m_data     = buf_q[head_q];
    assign bus.fifo_rd_en = rd_en;

`ifdef DRAIN_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Statistics next-state: flush discards buffered words plus the landing word, minus a popped beat
    always_comb begin
        beat_cnt_d = beat_cnt_q + {31'd0, pop};
        drop_cnt_d = drop_cnt_q;
        if (bus.flush) begin
            drop_cnt_d = drop_cnt_q + {29'd0, level} - {31'd0, pop};
        end
    end

    // Statistics registers, wrapping naturally at 32 bits
    always_ff @(posedge clock) begin
        if (rst) begin
            beat_cnt_q <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_drain.sv
// tb_sync_fifo_drain: drives sync_fifo_drain from a simple FIFO model and
// scoreboards the output stream against the words written into that FIFO.
module tb_sync_fifo_drain;
    localparam int DW = 64;

    logic clock = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sync_fifo_drain_if #(.DATA_WIDTH(DW)) bus_if ();

`ifdef DRAIN_STATS_EN
    logic [31:0] beat_cnt;
    logic [31:0] drop_cnt;
`endif

    sync_fifo_drain #(.DATA_WIDTH(DW)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_if)
`ifdef DRAIN_STATS_EN
        ,
        .beat_cnt (beat_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    // FIFO model: registered dout with one-cycle read latency
    logic [DW-1:0] mem [0:255];
    logic [7:0]    wr_ptr = 8'd0;
    logic [7:0]    rd_ptr = 8'd0;
    logic [DW-1:0] exp_q [$];
    int            lvl = 0;

    assign bus_if.fifo_empty = (rd_ptr == wr_ptr);

    // FIFO model: return the head word one cycle after a read request
    always @(posedge clock) begin
        if (bus_if.fifo_rd_en) begin
            bus_if.fifo_dout <= mem[rd_ptr];
            rd_ptr           <= rd_ptr + 8'd1;
        end
    end

    // Reads issued minus beats delivered, i.e. words held or in flight in the controller
    always @(posedge clock) begin
        if (rst || bus_if.flush) lvl <= 0;
        else lvl <= lvl + int'(bus_if.fifo_rd_en) - int'(bus_if.m_valid && bus_if.m_ready);
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        logic [DW-1:0] w;
        rst = 1'b1;
        bus_if.flush = 1'b0;
        bus_if.m_ready = 1'b0;
        next_cycle();
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            w = DW'(8'h10 + i);
            push_word(w);
        end
        #1;
        n_checks++;
        if (bus_if.m_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_m_valid got %0b want 0", bus_if.m_valid);
        end
        n_checks++;
        if (bus_if.fifo_rd_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_rd_en got %0b want 0", bus_if.fifo_rd_en);
        end
`ifdef DRAIN_STATS_EN
        next_cycle();
        n_checks++;
        if (beat_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", beat_cnt, drop_cnt);
        end
`endif
    endtask

    task automatic test_in_order();
        int first_rd = -1;
        int first_v  = -1;
        int beats    = 0;
        int gaps     = 0;
        int last     = 0;
        logic [DW-1:0] e;
        rst = 1'b0;
        bus_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (bus_if.fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (bus_if.m_valid && first_v < 0) first_v = cyc;
            if (bus_if.m_valid && bus_if.m_ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (bus_if.m_data !== e) begin
                    n_fail++; $display("[TB] FAIL in_order_data got %0h want %0h", bus_if.m_data, e);
                end
                if (beats > 0 && cyc != last + 1) gaps++;
                last = cyc;
                beats++;
            end
            next_cycle();
        end
        n_checks++;
        if (first_rd < 0 || first_v - first_rd != 2) begin
            n_fail++; $display("[TB] FAIL first_latency got %0d want 2", first_v - first_rd);
        end
        n_checks++;
        if (beats != 8 || gaps != 0) begin
            n_fail++; $display("[TB] FAIL in_order_beats got %0d beats %0d gaps want 8 beats 0 gaps", beats, gaps);
        end
        n_checks++;
        if (bus_if.m_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL in_order_idle got %0b want 0", bus_if.m_valid);
        end
    endtask

    task automatic test_backpressure();
        int rd_pulses = 0;
        int hold_bad  = 0;
        int beats     = 0;
        int gaps      = 0;
        logic [DW-1:0] w, e;
        bus_if.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = DW'(8'hA0 + i);
            push_word(w);
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (bus_if.fifo_rd_en) rd_pulses++;
            if (bus_if.m_valid && bus_if.m_data !== DW'(8'hA0)) hold_bad++;
            next_cycle();
        end
        n_checks++;
        if (rd_pulses != 2) begin
            n_fail++; $display("[TB] FAIL stall_reads got %0d want 2", rd_pulses);
        end
        n_checks++;
        if (hold_bad != 0 || bus_if.m_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL stall_hold got %0d bad cycles valid %0b want 0 bad valid 1", hold_bad, bus_if.m_valid);
        end
        bus_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (bus_if.m_valid && bus_if.m_ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (bus_if.m_data !== e) begin
                    n_fail++; $display("[TB] FAIL release_data got %0h want %0h", bus_if.m_data, e);
                end
                if (cyc != beats) gaps++;
                beats++;
            end
            next_cycle();
        end
        n_checks++;
        if (beats != 8 || gaps != 0) begin
            n_fail++; $display("[TB] FAIL release_beats got %0d beats %0d gaps want 8 beats 0 gaps", beats, gaps);
        end
    endtask

    task automatic test_toggle();
        int beats = 0;
        logic [DW-1:0] w, e;
        for (int i = 0; i < 16; i++) begin
            w = DW'(i);
            push_word(w);
        end
        for (int cyc = 0; cyc < 100 && beats < 16; cyc++) begin
            bus_if.m_ready = (cyc % 2 == 0);
            #1;
            n_checks++;
            if (lvl > 2) begin
                n_fail++; $display("[TB] FAIL occ_bound got %0d want <=2", lvl);
            end
            if (bus_if.m_valid && bus_if.m_ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (bus_if.m_data !== e) begin
                    n_fail++; $display("[TB] FAIL toggle_data got %0h want %0h", bus_if.m_data, e);
                end
                beats++;
            end
            next_cycle();
        end
        n_checks++;
        if (beats != 16) begin
            n_fail++; $display("[TB] FAIL toggle_beats got %0d want 16", beats);
        end
        bus_if.m_ready = 1'b1;
    endtask

    task automatic test_flush();
        int beats = 0;
        logic [31:0] drop_before = 32'd0;
        logic [DW-1:0] w, e;
        bus_if.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = DW'(8'h30 + i);
            push_word(w);
        end
        for (int cyc = 0; cyc < 4; cyc++) next_cycle();
`ifdef DRAIN_STATS_EN
        drop_before = drop_cnt;
`endif
        bus_if.flush = 1'b1;
        #1;
        n_checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== DW'(8'h30) || bus_if.fifo_rd_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_entry got valid %0b data %0h rd %0b want 1 30 0",
                               bus_if.m_valid, bus_if.m_data, bus_if.fifo_rd_en);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        next_cycle();
        bus_if.flush = 1'b0;
        #1;
        n_checks++;
        if (bus_if.m_valid !== 1'b0 || bus_if.fifo_rd_en !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_after got valid %0b rd %0b want 0 1", bus_if.m_valid, bus_if.fifo_rd_en);
        end
        next_cycle();
        bus_if.flush = 1'b1;
        #1;
        n_checks++;
        if (bus_if.fifo_rd_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_landing_rd got %0b want 0", bus_if.fifo_rd_en);
        end
        void'(exp_q.pop_front());
        next_cycle();
        bus_if.flush = 1'b0;
        bus_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (bus_if.m_valid && bus_if.m_ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (bus_if.m_data !== e) begin
                    n_fail++; $display("[TB] FAIL flush_resume_data got %0h want %0h", bus_if.m_data, e);
                end
                beats++;
            end
            next_cycle();
        end
        n_checks++;
        if (beats != 5) begin
            n_fail++; $display("[TB] FAIL flush_resume_beats got %0d want 5", beats);
        end
`ifdef DRAIN_STATS_EN
        n_checks++;
        if (drop_cnt - drop_before !== 32'd3) begin
            n_fail++; $display("[TB] FAIL drop_cnt got %0d want 3", drop_cnt - drop_before);
        end
`else
        drop_before = 32'd0;
`endif
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        logic [DW-1:0] w, e;
        bus_if.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = DW'(8'h50 + i);
            push_word(w);
        end
        for (int cyc = 0; cyc < 20 && beats < 3; cyc++) begin
            #1;
            if (bus_if.m_valid && bus_if.m_ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (bus_if.m_data !== e) begin
                    n_fail++; $display("[TB] FAIL pre_reset_data got %0h want %0h", bus_if.m_data, e);
                end
                beats++;
            end
            next_cycle();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus_if.m_valid !== 1'b0 || bus_if.fifo_rd_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_reset_outputs got valid %0b rd %0b want 0 0", bus_if.m_valid, bus_if.fifo_rd_en);
        end
        n_checks++;
        if (lvl != 2) begin
            n_fail++; $display("[TB] FAIL mid_reset_held got %0d want 2", lvl);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        next_cycle();
        rst = 1'b0;
        #1;
`ifdef DRAIN_STATS_EN
        n_checks++;
        if (beat_cnt !== 32'd0) begin
            n_fail++; $display("[TB] FAIL beat_cnt_after_reset got %0d want 0", beat_cnt);
        end
`endif
        beats = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) #1;
            if (bus_if.m_valid && bus_if.m_ready) begin
                n_checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (bus_if.m_data !== e) begin
                    n_fail++; $display("[TB] FAIL post_reset_data got %0h want %0h", bus_if.m_data, e);
                end
                beats++;
            end
            next_cycle();
        end
        n_checks++;
        if (beats != 3) begin
            n_fail++; $display("[TB] FAIL post_reset_beats got %0d want 3", beats);
        end
    endtask

    task automatic test_empty();
        int rd_pulses = 0;
        int valids    = 0;
        bus_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (bus_if.fifo_rd_en) rd_pulses++;
            if (bus_if.m_valid) valids++;
            next_cycle();
        end
        n_checks++;
        if (rd_pulses != 0) begin
            n_fail++; $display("[TB] FAIL empty_reads got %0d want 0", rd_pulses);
        end
        n_checks++;
        if (valids != 0) begin
            n_fail++; $display("[TB] FAIL empty_valid got %0d want 0", valids);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("[TB] FAIL leftover_expected got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_backpressure();
        test_toggle();
        test_flush();
        test_reset_mid();
        test_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
